// File: rtl/mem_cpu_param.sv
// Accumulator-style CPU that runs straight out of a single-port RAM with a ready handshake.
// Optional MUL instruction on opcode 7 is built only when MEM_CPU_MUL_EN is defined.
//
// state  | meaning
// FETCH  | present pCounter to RAM
// DECODE | latch opcode/A from the instruction word, present A (or the pointer address)
// IND1   | latch pointer P into A, present P
// IND2   | latch *A, present A again
// OPND   | latch *A, present W address
// EXEC   | W on data_fromRAM, execute, write back, advance pCounter
// HALT   | self-branch taken with W == 0, leave only through reset
module mem_cpu_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 13,
   parameter int W_ADDR   = 500,
   parameter int IND_ADDR = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_ready,
   input  logic [DATA_W-1:0] data_fromRAM,
   output logic              wrEn,
   output logic [ADDR_W-1:0] addr_toRAM,
   output logic [DATA_W-1:0] data_toRAM,
   output logic [ADDR_W-1:0] pCounter,
   output logic              halted
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_IND1   = 3'd2;
   localparam logic [2:0] S_IND2   = 3'd3;
   localparam logic [2:0] S_OPND   = 3'd4;
   localparam logic [2:0] S_EXEC   = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NAND = 3'd1;
   localparam logic [2:0] OP_SRL  = 3'd2;
   localparam logic [2:0] OP_LT   = 3'd3;
   localparam logic [2:0] OP_BZ   = 3'd4;
   localparam logic [2:0] OP_CP2W = 3'd5;
   localparam logic [2:0] OP_CPFW = 3'd6;

   localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(W_ADDR);
   localparam logic [ADDR_W-1:0] IND_A = ADDR_W'(IND_ADDR);
   localparam logic [DATA_W-1:0] DW_V  = DATA_W'(DATA_W);

   logic [2:0]        state;
   logic [2:0]        opcode_q;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] opnd_q;

   logic [2:0]        instr_op;
   logic [ADDR_W-1:0] instr_a;
   logic [DATA_W-1:0] w_val;
   logic [DATA_W-1:0] result;
   logic              writes;
   logic              br_taken;
   logic [ADDR_W-1:0] br_tgt;
   logic              halt_hit;

   assign instr_op = data_fromRAM[DATA_W-1 -: 3];
   assign instr_a  = data_fromRAM[ADDR_W-1:0];
   assign w_val    = data_fromRAM;

   always_comb begin
      result = '0;
      writes = 1'b1;
      case (opcode_q)
         OP_ADD:  result = opnd_q + w_val;
         OP_NAND: result = ~(opnd_q & w_val);
         OP_SRL: begin
            if (opnd_q <= DW_V) result = w_val >> opnd_q;
            else                result = w_val << (opnd_q - DW_V);
         end
         OP_LT:   result = {{(DATA_W-1){1'b0}}, (w_val < opnd_q)};
         OP_BZ:   writes = 1'b0;
         OP_CP2W: result = opnd_q;
         OP_CPFW: result = w_val;
         default: begin
`ifdef MEM_CPU_MUL_EN
            result = opnd_q * w_val;
`else
            writes = 1'b0;
`endif
         end
      endcase
   end

   assign br_tgt   = opnd_q[ADDR_W-1:0];
   assign br_taken = (opcode_q == OP_BZ) && (w_val == '0);
   assign halt_hit = br_taken && (br_tgt == pCounter);

   // DECODE and IND1 drive the address straight from the read data; a stalled
   // RAM keeps its read data, so the address stays put across ram_ready=0.
   always_comb begin
      addr_toRAM = '0;
      case (state)
         S_FETCH:  addr_toRAM = pCounter;
         S_DECODE: addr_toRAM = (instr_a != '0) ? instr_a : IND_A;
         S_IND1:   addr_toRAM = data_fromRAM[ADDR_W-1:0];
         S_IND2:   addr_toRAM = a_q;
         S_OPND:   addr_toRAM = W_A;
         S_EXEC:   addr_toRAM = (opcode_q == OP_CPFW) ? a_q : W_A;
         default:  addr_toRAM = '0;
      endcase
   end

   assign wrEn       = (state == S_EXEC) && ram_ready && writes;
   assign data_toRAM = wrEn ? result : '0;

   // Indirect path runs IND2 -> OPND so an indirect instruction takes six
   // cycles against four for a direct one; both stages latch the operand.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_FETCH;
         pCounter <= '0;
         halted   <= 1'b0;
         opcode_q <= '0;
         a_q      <= '0;
         opnd_q   <= '0;
      end else if (ram_ready) begin
         case (state)
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               opcode_q <= instr_op;
               a_q      <= instr_a;
               state    <= (instr_a != '0) ? S_OPND : S_IND1;
            end
            S_IND1: begin
               a_q   <= data_fromRAM[ADDR_W-1:0];
               state <= S_IND2;
            end
            S_IND2: begin
               opnd_q <= data_fromRAM;
               state  <= S_OPND;
            end
            S_OPND: begin
               opnd_q <= data_fromRAM;
               state  <= S_EXEC;
            end
            S_EXEC: begin
               if (halt_hit) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  pCounter <= br_taken ? br_tgt : pCounter + 1'b1;
                  state    <= S_FETCH;
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_cpu_param.sv
// Bench for mem_cpu_param: RAM model, instruction-level reference model and a
// write/pCounter scoreboard, plus directed latency, stall, halt and reset cases.
module tb_mem_cpu_param;
   localparam int DW       = 16;
   localparam int AW       = 13;
   localparam int W_ADDR   = 500;
   localparam int IND_ADDR = 4;
   localparam int MEM_N    = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ram_ready = 1'b1;
   logic [DW-1:0] data_fromRAM = '0;
   logic          wrEn;
   logic [AW-1:0] addr_toRAM;
   logic [DW-1:0] data_toRAM;
   logic [AW-1:0] pCounter;
   logic          halted;

   mem_cpu_param #(.DATA_W(DW), .ADDR_W(AW), .W_ADDR(W_ADDR), .IND_ADDR(IND_ADDR)) dut (
      .clk(clk), .rst(rst), .ram_ready(ram_ready), .data_fromRAM(data_fromRAM),
      .wrEn(wrEn), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM),
      .pCounter(pCounter), .halted(halted)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram       [MEM_N];
   logic [DW-1:0] init_mem  [MEM_N];
   logic [DW-1:0] model_mem [MEM_N];
   logic          copy_req = 1'b0;

   // RAM: one-cycle read latency, read data held while ram_ready is low
   always @(posedge clk) begin
      if (copy_req) begin
         for (int i = 0; i < MEM_N; i++) ram[i] <= init_mem[i];
      end else begin
         if (wrEn) ram[addr_toRAM] <= data_toRAM;
         if (ram_ready) data_fromRAM <= ram[addr_toRAM];
      end
   end

   typedef struct { int unsigned addr; int unsigned data; } wr_t;
   wr_t         exp_wr[$];
   int unsigned exp_pc[$];
   bit          exp_halt;
   int unsigned halt_pc;

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  mon_en = 1'b0;
   int  cyc = 0;
   int  last_wr_cyc = 0;
   logic [AW-1:0] last_pc = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: one loop iteration per instruction
   task automatic run_model(input int n);
      int unsigned pc, ins, op, a, v, w, res, dst, tgt;
      bit wr;
      pc = 0;
      exp_halt = 1'b0;
      for (int k = 0; k < n; k++) begin
         ins = model_mem[pc];
         op  = ins >> 13;
         a   = ins % MEM_N;
         if (a == 0) a = model_mem[IND_ADDR] % MEM_N;
         v   = model_mem[a];
         w   = model_mem[W_ADDR];
         wr  = 1'b1;
         dst = W_ADDR;
         res = 0;
         case (op)
            0: res = (v + w) % 65536;
            1: res = (~(v & w)) % 65536;
            2: begin
               if (v <= 16)           res = w >> v;
               else if (v - 16 >= 16) res = 0;
               else                   res = (w << (v - 16)) % 65536;
            end
            3: res = (w < v) ? 1 : 0;
            4: wr = 1'b0;
            5: res = v;
            6: begin dst = a; res = w; end
            default: begin
`ifdef MEM_CPU_MUL_EN
               res = int'((longint'(v) * longint'(w)) % 65536);
`else
               wr = 1'b0;
`endif
            end
         endcase
         if (wr) begin
            exp_wr.push_back('{dst, res});
            model_mem[dst] = DW'(res);
         end
         if (op == 4 && w == 0) begin
            tgt = v % MEM_N;
            if (tgt == pc) begin
               exp_halt = 1'b1;
               halt_pc  = pc;
               break;
            end
            pc = tgt;
         end else begin
            pc = (pc + 1) % MEM_N;
         end
         exp_pc.push_back(pc);
      end
   endtask

   function automatic logic [DW-1:0] gen_word();
      logic [DW-1:0] wd;
      case ($urandom_range(3))
         0:       wd = 16'($urandom_range(40));
         1:       wd = {3'($urandom_range(7)), 13'd0};
         2:       wd = {3'($urandom_range(7)), 13'($urandom_range(63, 1))};
         default: wd = 16'($urandom);
      endcase
      return wd;
   endfunction

   task automatic clear_init();
      for (int i = 0; i < MEM_N; i++) init_mem[i] = '0;
   endtask

   task automatic start_prog(input int n, input bit mon);
      rst = 1'b0;
      mon_en = 1'b0;
      ram_ready = 1'b1;
      #1;
      chk("rst_pc", pCounter, 0);
      chk("rst_halted", halted, 0);
      chk("rst_wren", wrEn, 0);
      chk("rst_addr", addr_toRAM, 0);
      chk("rst_data", data_toRAM, 0);
      copy_req = 1'b1;
      @(posedge clk); #1;
      copy_req = 1'b0;
      model_mem = init_mem;
      exp_wr.delete();
      exp_pc.delete();
      run_model(n);
      @(posedge clk); #1;
      rst = 1'b1;
      cyc = 0;
      last_pc = '0;
      last_wr_cyc = 0;
      mon_en = mon;
   endtask

   task automatic finish_prog(input int pct);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
         @(posedge clk); #1;
         if (pct < 100) ram_ready = ($urandom_range(99) < pct);
         if (exp_pc.size() == 0) done = 1'b1;
      end
      if (!done) chk("timeout_pending_pc", exp_pc.size(), 0);
      if (exp_halt) begin
         repeat (100) begin
            @(posedge clk); #1;
            if (pct < 100) ram_ready = ($urandom_range(99) < pct);
         end
         chk("halted", halted, 1);
         chk("halt_pc", pCounter, halt_pc);
         chk("halt_addr", addr_toRAM, 0);
      end
      mon_en = 1'b0;
      chk("pending_wr", exp_wr.size(), 0);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (mon_en) begin
               cyc++;
               if (wrEn) begin
                  if (exp_wr.size() == 0) begin
                     chk("unexpected_wr_addr", addr_toRAM, 'h7fffffff);
                  end else begin
                     wr_t e;
                     e = exp_wr.pop_front();
                     chk("wr_addr", addr_toRAM, e.addr);
                     chk("wr_data", data_toRAM, e.data);
                  end
                  last_wr_cyc = cyc;
               end
               if (pCounter != last_pc) begin
                  if (exp_pc.size() == 0) chk("unexpected_pc", pCounter, last_pc);
                  else                    chk("pc", pCounter, exp_pc.pop_front());
                  last_pc = pCounter;
               end
            end
         end
      join_none

      // ADD direct: 5 + 3 written at cycle 4
      clear_init();
      init_mem[0] = 16'h0014; init_mem[20] = 16'd5; init_mem[W_ADDR] = 16'd3;
      start_prog(1, 1'b1);
      finish_prog(100);
      chk("lat_direct", last_wr_cyc, 4);

      // CP2W through the pointer at IND_ADDR: write 7 at cycle 6
      clear_init();
      init_mem[0] = 16'hA000; init_mem[IND_ADDR] = 16'd30; init_mem[30] = 16'd7;
      init_mem[W_ADDR] = 16'd2;
      start_prog(1, 1'b1);
      finish_prog(100);
      chk("lat_indirect", last_wr_cyc, 6);

      // BZ to 5, then self-branch at 5 halts
      clear_init();
      init_mem[0] = 16'h8009; init_mem[5] = 16'h8009; init_mem[9] = 16'd5;
      start_prog(5, 1'b1);
      finish_prog(100);

      // three stall cycles in OPND of an ADD
      clear_init();
      init_mem[0] = 16'h0014; init_mem[20] = 16'd5; init_mem[W_ADDR] = 16'd3;
      start_prog(1, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      ram_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_wren", wrEn, 0);
         chk("stall_addr", addr_toRAM, W_ADDR);
      end
      @(posedge clk); #1;
      ram_ready = 1'b1;
      finish_prog(100);
      chk("lat_stalled", last_wr_cyc, 7);

      // reset in EXEC of CPfW suppresses the write
      clear_init();
      init_mem[0] = 16'hC014; init_mem[20] = 16'h0055; init_mem[W_ADDR] = 16'h1234;
      start_prog(1, 1'b0);
      repeat (4) @(negedge clk);
      chk("cpfw_exec_wren", wrEn, 1);
      chk("cpfw_exec_addr", addr_toRAM, 20);
      #1 rst = 1'b0;
      #1;
      chk("rst_exec_wren", wrEn, 0);
      chk("rst_exec_addr", addr_toRAM, 0);
      chk("rst_exec_data", data_toRAM, 0);
      chk("rst_exec_pc", pCounter, 0);
      chk("rst_exec_halted", halted, 0);
      @(posedge clk); #1;
      chk("rst_exec_nowrite", ram[20], 16'h0055);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("restart_wren", wrEn, 1);
      chk("restart_pc", pCounter, 0);
      rst = 1'b0;

      // opcode 7: MUL or NOP depending on the build
      clear_init();
      init_mem[0] = 16'hE014; init_mem[20] = 16'h0100; init_mem[W_ADDR] = 16'h0101;
      start_prog(1, 1'b1);
      finish_prog(100);

      // random programs against the model
      for (int r = 0; r < 6; r++) begin
         clear_init();
         for (int i = 0; i < 64; i++) init_mem[i] = gen_word();
         init_mem[W_ADDR] = ($urandom_range(3) == 0) ? '0 : gen_word();
         start_prog(60, 1'b1);
         finish_prog((r % 2 == 0) ? 100 : 70);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
